// File: rtl/geo_pixel_addr_gen.sv
// Pixel address generator: turns X/Y drawing requests into 40-bit pixel-writer commands.
// Latency 2 cycles (accept -> cmd_rdy); draw_busy freezes both stages, in_busy when S1 is held.
module geo_pixel_addr_gen #(
    parameter int ADDR_W = 20,
    parameter int XY_W   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_busy,
    input  logic [3:0]           in_cmd,
    input  logic [7:0]           in_colour,
    input  logic [XY_W-1:0]      in_x,
    input  logic [XY_W-1:0]      in_y,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [15:0]          cfg_width,
    input  logic [3:0]           cfg_bpp,
    input  logic [XY_W-1:0]      cfg_xmax,
    input  logic [XY_W-1:0]      cfg_ymax,
    input  logic                 draw_busy,
    output logic                 cmd_rdy,
    output logic [ADDR_W+19:0]   cmd_out,
    output logic [7:0]           clip_count,
    input  logic                 clip_rst
);
    localparam int CMD_W  = ADDR_W + 20;
    localparam int PROD_W = XY_W + 16;

    // S1: request plus the configuration it was accepted under
    logic              s1_vld;
    logic [3:0]        s1_cmd;
    logic [7:0]        s1_colour;
    logic [XY_W-1:0]   s1_x;
    logic [XY_W-1:0]   s1_y;
    logic [ADDR_W-1:0] s1_base;
    logic [15:0]       s1_width;
    logic [3:0]        s1_bpp;
    logic [XY_W-1:0]   s1_xmax;
    logic [XY_W-1:0]   s1_ymax;

    logic              s2_vld;
    logic [CMD_W-1:0]  s2_dat;

    logic              stall;
    logic              s1_en;
    logic              is_pix;
    logic              is_ctl;
    logic              bpp_ok;
    logic [2:0]        shamt;
    logic              clipped;
    logic              pix_ok;
    logic              counted_drop;
    logic              s1_pass;
    logic [XY_W-1:0]   x_word;
    logic [3:0]        tgt_mask;
    logic [3:0]        target;
    logic [ADDR_W-1:0] addr;
    logic [CMD_W-1:0]  s1_word;

    assign stall   = s2_vld && draw_busy;
    assign in_busy = s1_vld && stall;
    assign s1_en   = !in_busy;
    assign cmd_rdy = s2_vld && !draw_busy;
    assign cmd_out = s2_dat;

    always_comb begin
        is_pix = 1'b0;
        is_ctl = 1'b0;
        case (s1_cmd)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd6: is_pix = 1'b1;
            4'd7, 4'd10, 4'd11:           is_ctl = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        shamt  = 3'd0;
        bpp_ok = 1'b1;
        case (s1_bpp)
            4'd0:    shamt = 3'd4;
            4'd1:    shamt = 3'd3;
            4'd3:    shamt = 3'd2;
            4'd7:    shamt = 3'd1;
            4'd15:   shamt = 3'd0;
            default: bpp_ok = 1'b0;
        endcase
    end

    assign clipped      = (s1_x >= s1_xmax) || (s1_y >= s1_ymax);
    assign pix_ok       = is_pix && bpp_ok && !clipped;
    assign counted_drop = is_pix && !(bpp_ok && !clipped);
    assign s1_pass      = pix_ok || is_ctl;

    // Full y*width product, then wrap modulo the RAM address space
    assign x_word   = s1_x >> shamt;
    assign tgt_mask = (4'd1 << shamt) - 4'd1;
    assign target   = s1_x[3:0] & tgt_mask;
    assign addr     = s1_base
                    + ADDR_W'(PROD_W'(s1_y) * PROD_W'(s1_width))
                    + ADDR_W'(x_word);

    always_comb begin
        s1_word = {s1_cmd, s1_colour, {(CMD_W-12){1'b0}}};
        if (is_pix)
            s1_word = {s1_cmd, s1_colour, s1_bpp, target, addr};
    end

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_cmd    <= in_cmd;
            s1_colour <= in_colour;
            s1_x      <= in_x;
            s1_y      <= in_y;
            s1_base   <= cfg_base;
            s1_width  <= cfg_width;
            s1_bpp    <= cfg_bpp;
            s1_xmax   <= cfg_xmax;
            s1_ymax   <= cfg_ymax;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            if (s1_en)
                s1_vld <= in_valid;
            if (!stall) begin
                s2_vld <= s1_vld && s1_pass;
                if (s1_vld && s1_pass)
                    s2_dat <= s1_word;
            end
        end
    end

    // Drops are counted as S1 drains; a coincident clear wins
    always_ff @(posedge clk) begin
        if (reset || clip_rst)
            clip_count <= 8'd0;
        else if (s1_vld && !stall && counted_drop && clip_count != 8'hFF)
            clip_count <= clip_count + 8'd1;
    end
endmodule

// File: doc/geo_pixel_addr_gen.md
Name: geo_pixel_addr_gen

Overview:
- Pixel address generator (PAGET stage). Converts screen-coordinate drawing requests from the geometry engine into the 40-bit pixel commands consumed by the pixel-writer command FIFO.
- Computes word address, sub-word target and bpp code from X/Y and the current bitmap configuration.
- Clips off-screen pixels and honours the writer's draw_busy back-pressure.
- Sits between the geometry generator and the pixel writer.

Parameters:
- ADDR_W, 20, RAM word-address width; output address field width.
- XY_W, 12, coordinate width, unsigned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_busy  out  1  high = request not accepted this cycle
- in_cmd  in  4  command code
- in_colour  in  8  colour / pixel data
- in_x  in  12  X coordinate
- in_y  in  12  Y coordinate
- cfg_base  in  20  bitmap base word address
- cfg_width  in  16  words per raster line
- cfg_bpp  in  4  bpp code: 0=1b, 1=2b, 3=4b, 7=8b, 15=16b
- cfg_xmax  in  12  clip width; pixel visible when x < xmax
- cfg_ymax  in  12  clip height; pixel visible when y < ymax
- draw_busy  in  1  pixel-writer FIFO full
- cmd_rdy  out  1  cmd_out valid; writer loads on this pulse
- cmd_out  out  40  {cmd[39:36], colour[35:28], bpp[27:24], target[23:20], addr[19:0]}
- clip_count  out  8  saturating count of dropped pixels
- clip_rst  in  1  clears clip_count

Behaviour:
- Two-stage pipeline: S1 (decode/clip) and S2 (address/output register). The cfg_* inputs are sampled into S1 with each accepted request. Mid-stream config changes affect only later requests.
- Stall: stall = S2 valid && draw_busy. While stalled, S1 and S2 hold their contents.
- in_busy = S1 valid && stall. This is purely combinational.
- Accept: a request is accepted when in_valid && !in_busy.
- cmd_rdy = S2 valid && !draw_busy. It is high for exactly one cycle per command. At most one command is emitted per cycle.
- Latency: accept on cycle N gives cmd_rdy on cycle N+2 when there is no stall. Throughput is 1 per clock.
- Pixel commands are codes 1, 2, 3, 4 and 6.
  - Shift s: bpp 0→4, 1→3, 3→2, 7→1, 15→0.
  - x_word = x >> s.
  - target = x & ((1<<s)-1).
  - addr = (cfg_base + y*cfg_width + x_word) mod 2^20. The full product is computed and then truncated; wrap-around is legal.
  - bpp field = cfg_bpp.
- Clipping applies to pixel commands only. If x >= cfg_xmax or y >= cfg_ymax, the command is dropped in S1: it never reaches S2 and clip_count increments.
- An invalid cfg_bpp (any value other than 0/1/3/7/15) on a pixel command causes the command to be dropped and counted, the same as a clip.
- Control commands are codes 7, 10 and 11. They pass through unclipped as {cmd, colour, 28'h0}.
- Codes 0, 5, 8, 9 and 12–15 are dropped silently, with no count.
- Dropped commands create a pipeline bubble only. Order of all emitted commands equals acceptance order.
- clip_count saturates at 255.
  - clip_rst clears it to 0.
  - If clip_rst coincides with a drop, the result is 0 (the clear wins).
- Reset values: S1/S2 valid = 0, cmd_rdy = 0, in_busy = 0, cmd_out = 0, clip_count = 0.
- Reset mid-stream discards all in-flight commands; nothing is emitted after reset until a new request is accepted.
- draw_busy rising while S2 holds a command: cmd_rdy drops in that same cycle. The command stays in S2 and issues the first cycle draw_busy is low. No duplication, no loss.

Test Plan:
- Address, 4bpp: base=0x01000, width=40, bpp=3, xmax=ymax=640. Inputs cmd=1, colour=0x5A, x=13, y=2 → two cycles later cmd_rdy=1 and cmd_out=0x15A3101053.
- Bpp sweep at x=13, y=0, base=0, width=1: bpp=0 gives target 13, addr 0; bpp=1 gives target 5, addr 1; bpp=7 gives target 1, addr 6; bpp=15 gives target 0, addr 13.
- Clip: xmax=100, ymax=50. Send x=100 y=0, then x=0 y=50, then x=99 y=49 → only the third is emitted, clip_count=2. Assert clip_rst with a simultaneous clip → clip_count=0.
- Back-pressure: stream 6 back-to-back commands and hold draw_busy high for cycles 3–7 → in_busy asserts, all 6 emitted in order with no duplicates, one cmd_rdy per command.
- Passthrough/drop: send cmd 7 colour 0x33, then cmd 0, then cmd 12 → one output 0x7330000000. clip_count unchanged.
- Wrap and reset: base=0xFFFF0, width=0x100, y=1, x=0, bpp=15 → addr 0x000F0. Assert reset while two commands are in flight → no cmd_rdy afterward, clip_count=0.
